// File: rtl/psk_tx_pkg.sv
// -----------------------------------------------------------------------------
// psk_tx_pkg
// Shared types and helpers for the PSK transmit mapper:
//   - state_e  : transmit FSM states (IDLE, PRE, DATA)
//   - iq_t     : one signed 12-bit I/Q sample pair
//   - DEF_*    : default SPS / AMP / FIFO depth
//   - gray_map : pure Gray mapping of a 2-bit symbol onto the +/-amp grid
// -----------------------------------------------------------------------------
package psk_tx_pkg;

  localparam int DEF_SPS        = 32;
  localparam int DEF_AMP        = 1024;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [11:0] i;
    logic signed [11:0] q;
  } iq_t;

  // BPSK carries bit 0 on I only; QPSK puts bit 1 on I and bit 0 on Q.
  // A set bit selects the negative rail.
  function automatic iq_t gray_map(input logic [1:0]         bits,
                                   input logic               is_bpsk,
                                   input logic signed [11:0] amp);
    iq_t r;
    if (is_bpsk) begin
      r.i = bits[0] ? -amp : amp;
      r.q = '0;
    end else begin
      r.i = bits[1] ? -amp : amp;
      r.q = bits[0] ? -amp : amp;
    end
    return r;
  endfunction

endpackage

// File: rtl/psk_tx_fifo.sv
// -----------------------------------------------------------------------------
// psk_tx_fifo
// Synchronous 2-bit symbol FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
// Storage is written and read through one-hot entry selects.
//   i_clk       clock
//   i_rst_n     synchronous active-low reset (pointers only)
//   i_wr_en     push i_wr_data (ignored while full)
//   i_wr_data   symbol to store
//   i_rd_en     pop the head entry (ignored while empty)
//   o_rd_data   head entry (valid while !o_empty)
//   o_full      DEPTH entries stored
//   o_empty     no entries stored
// -----------------------------------------------------------------------------
module psk_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [1:0] i_wr_data,
  input  logic       i_rd_en,
  output logic [1:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  // NOTE: storage has no reset; only the pointers define which entries are live.
  logic [1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]  w_wr_sel;
  logic [DEPTH-1:0]  w_rd_sel;
  logic              w_push;
  logic              w_pop;

  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push   = i_wr_en && !o_full;
  assign w_pop    = i_rd_en && !o_empty;
  assign w_wr_sel = {{(DEPTH-1){1'b0}}, 1'b1} << r_wr_ptr[AW-1:0];
  assign w_rd_sel = {{(DEPTH-1){1'b0}}, 1'b1} << r_rd_ptr[AW-1:0];

  always_comb begin
    o_rd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_rd_sel[k]) o_rd_data |= r_mem[k];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (w_push && w_wr_sel[k]) r_mem[k] <= i_wr_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/psk_tx_mapper.sv
// -----------------------------------------------------------------------------
// psk_tx_mapper
// Baseband BPSK/QPSK transmit mapper. Symbols arrive over valid/ready, are
// buffered in psk_tx_fifo, Gray-mapped to +/-AMP and each held for SPS cycles.
// Optional macro PSK_TX_PREAMBLE_EN: every start from IDLE first sends PRE_LEN
// alternating symbols (00, 11, 00, ...) before FIFO data.
//   clk_16M384    sole clock
//   rst_n_16M384  synchronous active-low reset
//   is_bpsk       1 = BPSK (bit 0 only), sampled at each symbol load
//   in_bits/in_vld/in_rdy  symbol input handshake, in_rdy = FIFO not full
//   DAC_I/DAC_Q   signed sample of the symbol on air (0 when idle)
//   DAC_bits      symbol on air (bit 1 forced to 0 in BPSK)
//   DAC_vld       DAC_I/DAC_Q carry a symbol
//   underrun      pulse on a DATA boundary that finds the FIFO empty
// -----------------------------------------------------------------------------
module psk_tx_mapper
  import psk_tx_pkg::*;
#(
  parameter int SPS        = DEF_SPS,
  parameter int AMP        = DEF_AMP,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
`ifdef PSK_TX_PREAMBLE_EN
  ,
  parameter int PRE_LEN    = 16
`endif
) (
  input  logic               clk_16M384,
  input  logic               rst_n_16M384,
  input  logic               is_bpsk,
  input  logic [1:0]         in_bits,
  input  logic               in_vld,
  output logic               in_rdy,
  output logic signed [11:0] DAC_I,
  output logic signed [11:0] DAC_Q,
  output logic [1:0]         DAC_bits,
  output logic               DAC_vld,
  output logic               underrun
);

  localparam int                 CW    = $clog2(SPS);
  localparam logic signed [11:0] AMP12 = 12'(AMP);

  state_e        r_state;
  state_e        w_next_state;
  logic [CW-1:0] r_cnt;
  iq_t           r_iq;
  logic [1:0]    r_bits;
  logic          r_vld;

  logic          w_boundary;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_load;
  logic          w_clear;
  logic [1:0]    w_load_bits;
  logic [1:0]    w_fifo_data;

`ifdef PSK_TX_PREAMBLE_EN
  localparam int PW = $clog2(PRE_LEN) + 1;
  logic [PW-1:0] r_pre_idx;
`endif

  psk_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (clk_16M384),
    .i_rst_n   (rst_n_16M384),
    .i_wr_en   (in_vld),
    .i_wr_data (in_bits),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign in_rdy     = !w_full;
  assign w_boundary = (r_cnt == CW'(SPS - 1));
  // Empty is the registered FIFO state, so a write landing on this very
  // boundary cannot rescue the symbol stream.
  assign underrun   = (r_state == ST_DATA) && w_boundary && w_empty;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_clear      = 1'b0;
    w_load_bits  = w_fifo_data;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_load = 1'b1;
`ifdef PSK_TX_PREAMBLE_EN
          w_next_state = ST_PRE;
          w_load_bits  = 2'b00;
`else
          w_next_state = ST_DATA;
          w_pop        = 1'b1;
`endif
        end
      end
`ifdef PSK_TX_PREAMBLE_EN
      ST_PRE: begin
        if (w_boundary) begin
          w_load = 1'b1;
          if (r_pre_idx == PW'(PRE_LEN - 1)) begin
            w_next_state = ST_DATA;
            w_pop        = 1'b1;
          end else begin
            // Next preamble index is r_pre_idx+1: odd -> 11, even -> 00.
            w_load_bits = r_pre_idx[0] ? 2'b00 : 2'b11;
          end
        end
      end
`endif
      ST_DATA: begin
        if (w_boundary) begin
          if (w_empty) begin
            w_next_state = ST_IDLE;
            w_clear      = 1'b1;
          end else begin
            w_load = 1'b1;
            w_pop  = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_clear      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_16M384) begin
    if (!rst_n_16M384) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_iq    <= '0;
      r_bits  <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_iq   <= gray_map(w_load_bits, is_bpsk, AMP12);
        r_bits <= is_bpsk ? {1'b0, w_load_bits[0]} : w_load_bits;
        r_vld  <= 1'b1;
      end else if (w_clear) begin
        r_iq   <= '0;
        r_bits <= '0;
        r_vld  <= 1'b0;
      end
      // The counter idles at 0 so the first sample after a start is cnt 0.
      if (r_state == ST_IDLE || w_clear || w_boundary) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef PSK_TX_PREAMBLE_EN
  always_ff @(posedge clk_16M384) begin
    if (!rst_n_16M384 || r_state != ST_PRE) begin
      r_pre_idx <= '0;
    end else if (w_boundary) begin
      r_pre_idx <= r_pre_idx + 1'b1;
    end
  end
`endif

  assign DAC_I    = r_iq.i;
  assign DAC_Q    = r_iq.q;
  assign DAC_bits = r_bits;
  assign DAC_vld  = r_vld;

endmodule

// File: tb/tb_psk_tx_mapper.sv
// -----------------------------------------------------------------------------
// tb_psk_tx_mapper
// Self-checking bench for psk_tx_mapper. A symbol-level model (queue of
// accepted symbols, symbol-on-air with cycles left) predicts every output each
// cycle; directed sequences pin latency, mapping, backpressure and underrun
// with literal values; a randomized phase exercises rates, mode flips and
// resets. Honours PSK_TX_PREAMBLE_EN when it is defined for the DUT.
// -----------------------------------------------------------------------------
module tb_psk_tx_mapper;

  localparam int SPS     = 32;
  localparam int AMP     = 1024;
  localparam int DEPTH   = 4;
`ifdef PSK_TX_PREAMBLE_EN
  localparam int PRE_LEN = 16;
  localparam int PRE_CYC = PRE_LEN * SPS;
`else
  localparam int PRE_CYC = 0;
`endif

  logic               clk     = 1'b0;
  logic               rst_n   = 1'b0;
  logic               is_bpsk = 1'b0;
  logic [1:0]         in_bits = 2'b00;
  logic               in_vld  = 1'b0;
  logic               in_rdy;
  logic signed [11:0] dac_i;
  logic signed [11:0] dac_q;
  logic [1:0]         dac_bits;
  logic               dac_vld;
  logic               underrun;

  always #5 clk = ~clk;

  psk_tx_mapper dut (
    .clk_16M384   (clk),
    .rst_n_16M384 (rst_n),
    .is_bpsk      (is_bpsk),
    .in_bits      (in_bits),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .DAC_I        (dac_i),
    .DAC_Q        (dac_q),
    .DAC_bits     (dac_bits),
    .DAC_vld      (dac_vld),
    .underrun     (underrun)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit saw_full    = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int q[$];            // accepted symbols not yet on air
  bit m_armed  = 0;    // model valid once a reset edge has been seen
  bit m_active = 0;    // a symbol is on air
  int m_left   = 0;    // cycles of the current symbol still to show
  int m_bits   = 0;
  int m_i      = 0;
  int m_q      = 0;
  int m_pre    = 0;    // preamble symbols sent so far in this burst (0 = data)

  task automatic m_show(input int b);
    if (is_bpsk) begin
      m_bits = b & 1;
      m_i    = (b & 1) ? -AMP : AMP;
      m_q    = 0;
    end else begin
      m_bits = b;
      m_i    = (b & 2) ? -AMP : AMP;
      m_q    = (b & 1) ? -AMP : AMP;
    end
    m_left   = SPS;
    m_active = 1;
  endtask

  task automatic m_idle();
    m_active = 0;
    m_left   = 0;
    m_bits   = 0;
    m_i      = 0;
    m_q      = 0;
    m_pre    = 0;
  endtask

  task automatic m_next();
`ifdef PSK_TX_PREAMBLE_EN
    if (m_pre > 0 && m_pre < PRE_LEN) begin
      m_show((m_pre % 2) ? 3 : 0);
      m_pre++;
      return;
    end
    m_pre = 0;
`endif
    if (q.size() > 0) m_show(q.pop_front());
    else m_idle();
  endtask

  always @(posedge clk) begin
    bit wr;
    int wbits;
    wr    = in_vld && (q.size() < DEPTH);
    wbits = in_bits;
    if (!rst_n) begin
      q.delete();
      m_idle();
      m_armed = 1;
    end else if (m_armed) begin
      if (!m_active) begin
        if (q.size() > 0) begin
`ifdef PSK_TX_PREAMBLE_EN
          m_show(0);
          m_pre = 1;
`else
          m_show(q.pop_front());
`endif
        end
      end else if (m_left > 1) begin
        m_left--;
      end else begin
        m_next();
      end
      if (wr) q.push_back(wbits);
    end
  end

  // One compare process: every output, every cycle, on the falling edge.
  always @(negedge clk) begin
    if (m_armed) begin
      check("in_rdy",   in_rdy,   int'(q.size() < DEPTH));
      check("DAC_vld",  dac_vld,  m_active);
      check("DAC_I",    dac_i,    m_i);
      check("DAC_Q",    dac_q,    m_q);
      check("DAC_bits", dac_bits, m_bits);
      check("underrun", underrun,
            int'(m_active && m_left == 1 && q.size() == 0 && m_pre == 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  // Present b and hold it until the DUT accepts it (bounded).
  task automatic write_sym(input int b);
    int guard;
    bit acc;
    guard   = 0;
    acc     = 0;
    in_vld  = 1'b1;
    in_bits = b[1:0];
    while (!acc) begin
      acc = in_rdy;
      if (!acc) saw_full = 1;
      tick();
      guard++;
      if (!acc && guard > 8 * SPS * DEPTH + PRE_CYC) begin
        check("write_accept_timeout", 0, 1);
        acc = 1;
      end
    end
  endtask

  task automatic wait_vld(input string name);
    int guard;
    guard = 0;
    while (!dac_vld && guard < 4 * SPS + PRE_CYC) begin
      tick();
      guard++;
    end
    check(name, dac_vld, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int rate;
    // ---- reset ----
    rst_n = 1'b0;
    wait_cycles(4);
    rst_n = 1'b1;
    tick();
    #3;
    check("rst_in_rdy",   in_rdy,   1);
    check("rst_DAC_vld",  dac_vld,  0);
    check("rst_DAC_I",    dac_i,    0);
    check("rst_DAC_Q",    dac_q,    0);
    check("rst_DAC_bits", dac_bits, 0);
    check("rst_underrun", underrun, 0);

`ifndef PSK_TX_PREAMBLE_EN
    // ---- QPSK mapping, latency, back-to-back, underrun ----
    is_bpsk = 1'b0;
    in_vld  = 1'b1;
    in_bits = 2'b00;
    tick();                               // write at t
    #3 check("lat_t1_vld", dac_vld, 0);
    in_bits = 2'b01;
    tick();                               // cycle t+2
    #3;
    check("lat_t2_vld", dac_vld, 1);
    check("qpsk00_I",   dac_i,   1024);
    check("qpsk00_Q",   dac_q,   1024);
    in_bits = 2'b10;
    tick();
    in_bits = 2'b11;
    tick();                               // cycle t+4
    in_vld = 1'b0;
    wait_cycles(29);                      // t+33, last cycle of symbol 00
    #3 check("qpsk00_hold_bits", dac_bits, 0);
    tick();                               // t+34
    #3;
    check("qpsk01_I",    dac_i,    1024);
    check("qpsk01_Q",    dac_q,    -1024);
    check("qpsk01_bits", dac_bits, 1);
    wait_cycles(32);                      // t+66
    #3;
    check("qpsk10_I", dac_i, -1024);
    check("qpsk10_Q", dac_q, 1024);
    wait_cycles(32);                      // t+98
    #3;
    check("qpsk11_I", dac_i, -1024);
    check("qpsk11_Q", dac_q, -1024);
    wait_cycles(31);                      // t+129, boundary with FIFO empty
    #3 check("underrun_pulse", underrun, 1);
    tick();
    #3;
    check("underrun_after",  underrun, 0);
    check("idle_vld",        dac_vld,  0);
    check("idle_I",          dac_i,    0);
    // ---- restart latency ----
    in_vld  = 1'b1;
    in_bits = 2'b10;
    tick();
    in_vld = 1'b0;
    #3 check("restart_t1_vld", dac_vld, 0);
    tick();
    #3;
    check("restart_t2_vld", dac_vld, 1);
    check("restart_I",      dac_i,   -1024);
    check("restart_Q",      dac_q,   1024);
    wait_cycles(2 * SPS);
`else
    // ---- preamble then data ----
    is_bpsk = 1'b0;
    in_vld  = 1'b1;
    in_bits = 2'b11;
    tick();
    in_vld = 1'b0;
    #3 check("pre_t1_vld", dac_vld, 0);
    tick();
    #3;
    check("pre0_vld",  dac_vld,  1);
    check("pre0_bits", dac_bits, 0);
    check("pre0_I",    dac_i,    1024);
    wait_cycles(SPS);
    #3;
    check("pre1_bits", dac_bits, 3);
    check("pre1_I",    dac_i,    -1024);
    wait_cycles(PRE_CYC - SPS);           // t+2+PRE_LEN*SPS
    #3;
    check("data_after_pre_I", dac_i, -1024);
    check("data_after_pre_Q", dac_q, -1024);
    wait_cycles(2 * SPS);
    // ---- reset mid-preamble ----
    write_sym(1);
    write_sym(2);
    in_vld = 1'b0;
    wait_cycles(100);
    rst_n = 1'b0;
    tick();
    #3;
    check("abort_vld",    dac_vld, 0);
    check("abort_I",      dac_i,   0);
    check("abort_in_rdy", in_rdy,  1);
    rst_n = 1'b1;
    wait_cycles(4);
    #3 check("abort_stays_idle", dac_vld, 0);
`endif

    // ---- BPSK ----
    is_bpsk = 1'b1;
    in_vld  = 1'b1;
    in_bits = 2'b01;
    tick();
    in_bits = 2'b10;
    tick();
    in_vld = 1'b0;
    wait_vld("bpsk_start");
    wait_cycles(PRE_CYC);
    #3;
    check("bpsk01_I",    dac_i,    -1024);
    check("bpsk01_Q",    dac_q,    0);
    check("bpsk01_bits", dac_bits, 1);
    wait_cycles(SPS);
    #3;
    check("bpsk10_I",    dac_i,    1024);
    check("bpsk10_Q",    dac_q,    0);
    check("bpsk10_bits", dac_bits, 0);
    wait_cycles(2 * SPS);
    is_bpsk = 1'b0;

    // ---- full / backpressure, order checked by the model ----
    saw_full = 0;
    for (int k = 0; k < 8; k++) write_sym(k % 4);
    in_vld = 1'b0;
    check("backpressure_seen", saw_full, 1);
    wait_cycles(PRE_CYC + 10 * SPS);

    // ---- randomized traffic ----
    for (int c = 0; c < 9000; c++) begin
      rate = (c < 3000) ? 20 : ((c < 6000) ? 3 : 70);
      if (!(in_vld && !in_rdy)) begin
        in_vld  = ($urandom_range(0, 99) < rate);
        in_bits = 2'($urandom);
      end
      if ($urandom_range(0, 149) == 0) is_bpsk = ~is_bpsk;
      rst_n = ($urandom_range(0, 2499) != 0);
      tick();
    end
    in_vld = 1'b0;
    rst_n  = 1'b1;
    wait_cycles(PRE_CYC + 6 * SPS);
    #3 check("final_idle_vld", dac_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
